// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution unit: FSM encoding, default
// history width and the sequential-PC increment.
package branch_resolve_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } state_e;

   localparam int          SHIFT_DEFAULT = 8;
   localparam logic [31:0] PC_INC        = 32'd4;

endpackage

// File: rtl/branch_resolve_if.sv
// Fetch/execute <-> branch_resolve signal bundle. The master side is the
// pipeline (fetch and execute); the slave side is the resolution unit.
interface branch_resolve_if
   import branch_resolve_pkg::*;
#(
   parameter int SHIFT = SHIFT_DEFAULT
) ();

   logic             pred_valid;
   logic             pred_taken;
   logic [31:0]      pred_pc;
   logic [SHIFT-1:0] pred_hist;

   logic             res_valid;
   logic             res_taken;
   logic [31:0]      res_target;

   logic             upd_valid;
   logic [31:0]      upd_pc;
   logic [SHIFT-1:0] upd_hist;
   logic             upd_taken;

   logic             mispredict;
   logic [31:0]      redirect_pc;
   logic [SHIFT-1:0] spec_hist;
   logic             full;
   logic             empty;

   modport master (
      output pred_valid, pred_taken, pred_pc, pred_hist,
      output res_valid, res_taken, res_target,
      input  upd_valid, upd_pc, upd_hist, upd_taken,
      input  mispredict, redirect_pc, spec_hist, full, empty
   );

   modport slave (
      input  pred_valid, pred_taken, pred_pc, pred_hist,
      input  res_valid, res_taken, res_target,
      output upd_valid, upd_pc, upd_hist, upd_taken,
      output mispredict, redirect_pc, spec_hist, full, empty
   );

endinterface

// File: rtl/branch_fifo.sv
// In-flight branch queue: {pc, taken, hist} entries in program order, with a
// single-cycle flush that discards every entry on a mispredict.
module branch_fifo #(
   parameter int DEPTH = 4,
   parameter int SHIFT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [31:0]      push_pc,
   input  logic             push_taken,
   input  logic [SHIFT-1:0] push_hist,
   output logic [31:0]      head_pc,
   output logic             head_taken,
   output logic [SHIFT-1:0] head_hist,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      pc_mem    [DEPTH];
   logic             taken_mem [DEPTH];
   logic [SHIFT-1:0] hist_mem  [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   // NOTE: entry storage has no reset; count/pointers alone decide validity.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= push_pc;
         taken_mem[wr_ptr] <= push_taken;
         hist_mem[wr_ptr]  <= push_hist;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   assign head_pc    = pc_mem[rd_ptr];
   assign head_taken = taken_mem[rd_ptr];
   assign head_hist  = hist_mem[rd_ptr];
   assign full       = (count == CNT_W'(DEPTH));
   assign empty      = (count == '0);

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution: compares resolved direction with the queued prediction,
// trains the predictor, repairs speculative history and requests flushes.
// Optional statistics counters are enabled with `define BRANCH_STATS_EN.
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int SHIFT = SHIFT_DEFAULT
) (
   input logic             clk,
   input logic             rst,
   branch_resolve_if.slave bus
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     branch_cnt,
   output logic [31:0]     correct_cnt
`endif
);

   state_e           state;
   state_e           next_state;
   logic             push;
   logic             pop;
   logic             mis;
   logic [31:0]      head_pc;
   logic             head_taken;
   logic [SHIFT-1:0] head_hist;

   branch_fifo #(
      .DEPTH (DEPTH),
      .SHIFT (SHIFT)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .flush      (mis),
      .push_pc    (bus.pred_pc),
      .push_taken (bus.pred_taken),
      .push_hist  (bus.pred_hist),
      .head_pc    (head_pc),
      .head_taken (head_taken),
      .head_hist  (head_hist),
      .full       (bus.full),
      .empty      (bus.empty)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= next_state;
   end

   // NOTE: every always_comb output gets a default first, so no latches.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      mis        = 1'b0;
      push       = 1'b0;
      unique case (state)
         RUN: begin
            pop  = bus.res_valid && !bus.empty;
            mis  = pop && (bus.res_taken != head_taken);
            // A pop frees a slot this cycle, so a full queue still accepts.
            push = bus.pred_valid && (!bus.full || pop) && !mis;
            if (mis) next_state = RECOVER;
         end
         RECOVER: next_state = RUN;
         default: next_state = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.upd_valid   <= 1'b0;
         bus.upd_pc      <= '0;
         bus.upd_hist    <= '0;
         bus.upd_taken   <= 1'b0;
         bus.mispredict  <= 1'b0;
         bus.redirect_pc <= '0;
         bus.spec_hist   <= '0;
      end else begin
         bus.upd_valid  <= pop;
         bus.mispredict <= mis;
         if (pop) begin
            bus.upd_pc      <= head_pc;
            bus.upd_hist    <= head_hist;
            bus.upd_taken   <= bus.res_taken;
            bus.redirect_pc <= bus.res_taken ? bus.res_target : head_pc + PC_INC;
         end
         // Recovery rebuilds history from the snapshot taken at prediction.
         if (mis)       bus.spec_hist <= {head_hist[SHIFT-2:0], bus.res_taken};
         else if (push) bus.spec_hist <= {bus.spec_hist[SHIFT-2:0], bus.pred_taken};
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt  <= '0;
         correct_cnt <= '0;
      end else if (pop) begin
         branch_cnt <= branch_cnt + 32'd1;
         if (!mis) correct_cnt <= correct_cnt + 32'd1;
      end
   end
`endif

endmodule
